// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
//   arb_state_t : sequencer states (IDLE, ISSUE, READ)
//   data_w()    : data width derived from the address width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

    // Memory words are twice as wide as the address.
    function automatic int unsigned data_w(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: picks one requester out of a valid vector.
//   Default build: round-robin, searching upward from ptr_i modulo NREQ.
//   MEM_ARB_FIXED_PRIO_EN defined: lowest index wins and ptr_i is ignored.
// Ports:
//   valid_i [NREQ]  : request vector
//   ptr_i   [IDX_W] : round-robin start index
//   grant_o [NREQ]  : one-hot winner (zero when nothing is valid)
//   idx_o   [IDX_W] : winner index
//   any_o           : at least one request is valid
module rr_picker #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Lowest-index valid requester wins.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && valid_i[IDX_W'(k)]) begin
                found = 1'b1;
                idx_o = IDX_W'(k);
            end
        end
    end
`else
    int unsigned cand;

    // First valid requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_i) + k) % NREQ;
            if (!found && valid_i[IDX_W'(cand)]) begin
                found = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end
`endif

    assign any_o   = found;
    assign grant_o = found ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory (registered read, read-enable
// gated output) between NREQ requesters, one command at a time.
// Optional build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no pointer register); default is round-robin.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/write   : per-requester command valid / write(1) read(0)
//   req_addr/wdata    : packed per-requester address / write data
//   req_ready         : one-hot accept, only in IDLE
//   rsp_valid         : one-cycle completion pulse to the command owner
//   rsp_rdata         : read data, updated only when a read completes
//   memoryWrite/Read  : memory write enable / read output gate
//   memoryAddress     : memory address, holds in IDLE
//   memoryWriteData   : memory write data, holds in IDLE
//   memoryOutData     : memory read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ*WIDTH-1:0]     req_addr,
    input  logic [NREQ*2*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [2*WIDTH-1:0]        rsp_rdata,
    output logic                      memoryWrite,
    output logic                      memoryRead,
    output logic [WIDTH-1:0]          memoryAddress,
    output logic [2*WIDTH-1:0]        memoryWriteData,
    input  logic [2*WIDTH-1:0]        memoryOutData
);

    localparam int unsigned DATA_W = data_w(WIDTH);
    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t         state_q;
    logic [IDX_W-1:0]   owner_q;
    logic               write_q;
    logic [WIDTH-1:0]   addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [NREQ-1:0]    rsp_valid_q;

    logic [IDX_W-1:0]   rr_ptr;
    logic [NREQ-1:0]    pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0]   ptr_q;
    assign rr_ptr = ptr_q;
`endif

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant is only offered while idle; the winner is valid by construction.
    assign req_ready = (state_q == IDLE) ? pick_grant : '0;

    // Sequencer: latch the winning command, drive the memory, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        write_q <= req_write[pick_idx];
                        addr_q  <= req_addr[32'(pick_idx) * WIDTH +: WIDTH];
                        wdata_q <= req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
`ifndef MEM_ARB_FIXED_PRIO_EN
                        if (32'(pick_idx) == NREQ - 1) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= pick_idx + IDX_W'(1);
                        end
`endif
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_q) begin
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= READ;
                    end
                end
                READ: begin
                    rdata_q     <= memoryOutData;
                    rsp_valid_q <= NREQ'(1) << owner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from registers, so reset drops them at once.
    assign memoryWrite     = (state_q == ISSUE) && write_q;
    assign memoryRead      = (state_q == READ);
    assign memoryAddress   = addr_q;
    assign memoryWriteData = wdata_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned DEPTH = 1 << WIDTH;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*WIDTH-1:0] req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 memoryWrite;
    logic                 memoryRead;
    logic [WIDTH-1:0]     memoryAddress;
    logic [DW-1:0]        memoryWriteData;
    logic [DW-1:0]        memoryOutData;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .memoryWrite     (memoryWrite),
        .memoryRead      (memoryRead),
        .memoryAddress   (memoryAddress),
        .memoryWriteData (memoryWriteData),
        .memoryOutData   (memoryOutData)
    );

    // Single-port memory: registered read, output gated by read enable.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    logic [DW-1:0] mem_rd_q = '0;
    always @(posedge clk) begin
        if (memoryWrite) mem[memoryAddress] <= memoryWriteData;
        mem_rd_q <= mem[memoryAddress];
    end
    assign memoryOutData = memoryRead ? mem_rd_q : '0;

    // Reference model: transaction schedule in absolute cycle numbers.
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    int            cyc = 0;
    int            ref_ptr = 0;
    int            free_at = 0;
    int            issue_at = -1;
    int            read_at = -1;
    int            rsp_at = -1;
    int            own = 0;
    bit            own_wr = 1'b0;
    int            own_addr = 0;
    logic [DW-1:0] own_wdata = '0;
    logic [DW-1:0] last_rdata = '0;

    logic [NREQ-1:0] seen_grants[$];
    int              rsp_cycles[$];
    logic [DW-1:0]   rsp_datas[$];
    int              last_grant_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, compare, advance model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                        input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*DW-1:0] d);
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rsp;
        int g;
        one = 1;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        #1;
        g = -1;
        if (cyc >= free_at) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (ref_ptr + k) % NREQ;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? (one << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rsp = (cyc == rsp_at) ? (one << own) : '0;
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (cyc == rsp_at) begin
            if (own_wr) ref_mem[own_addr] = own_wdata;
            else        last_rdata = ref_mem[own_addr];
        end
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        check("mem_write", 32'(memoryWrite), 32'(cyc == issue_at && own_wr));
        check("mem_read", 32'(memoryRead), 32'(cyc == read_at));
        if (cyc == issue_at) begin
            check("mem_addr", 32'(memoryAddress), 32'(own_addr));
            if (own_wr) check("mem_wdata", 32'(memoryWriteData), 32'(own_wdata));
        end
        if (req_ready != '0) begin
            seen_grants.push_back(req_ready);
            last_grant_cyc = cyc;
        end
        if (rsp_valid != '0) begin
            rsp_cycles.push_back(cyc);
            rsp_datas.push_back(rsp_rdata);
        end
        if (g >= 0) begin
            own       = g;
            own_wr    = w[g];
            own_addr  = int'(a[g*WIDTH +: WIDTH]);
            own_wdata = d[g*DW +: DW];
            issue_at  = cyc + 1;
            read_at   = own_wr ? -1 : cyc + 2;
            rsp_at    = own_wr ? cyc + 2 : cyc + 3;
            free_at   = rsp_at;
            ref_ptr   = FIXED ? 0 : (g + 1) % NREQ;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    // Assert reset mid-cycle, check outputs clear before any edge.
    task automatic do_reset();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_mem_write", 32'(memoryWrite), 32'd0);
        check("rst_mem_read", 32'(memoryRead), 32'd0);
        check("rst_mem_addr", 32'(memoryAddress), 32'd0);
        check("rst_mem_wdata", 32'(memoryWriteData), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        ref_ptr = 0; free_at = cyc; issue_at = -1; read_at = -1; rsp_at = -1;
        last_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        @(negedge clk);
        do_reset();

        // Write 0x1234 to 0x05, preload, then read it back.
        step(2'b01, 2'b01, {8'h00, 8'h05}, {16'h0000, 16'h1234});
        idle(2);
        step(2'b01, 2'b01, {8'h00, 8'h01}, {16'h0000, 16'hAAAA}); idle(2);
        step(2'b01, 2'b01, {8'h00, 8'h02}, {16'h0000, 16'h5555}); idle(2);
        step(2'b01, 2'b01, {8'h00, 8'h10}, {16'h0000, 16'h0F0F}); idle(2);
        step(2'b01, 2'b00, {8'h00, 8'h05}, '0);
        idle(3);
        check("t1_rdata", 32'(rsp_rdata), 32'h1234);

        // Both requesters continuously valid from a fresh pointer.
        do_reset();
        seen_grants.delete();
        for (int i = 0; i < 40 && seen_grants.size() < 8; i++)
            step(2'b11, 2'b11, {8'h21, 8'h20}, {16'h2222, 16'h1111});
        idle(2);
        check("t2_ngrants", 32'(seen_grants.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen_grants.size(); i++)
            check("t2_grant", 32'(seen_grants[i]),
                  32'((FIXED || i % 2 == 0) ? 2'b01 : 2'b10));

        // Top address write by req0, read by req1.
        step(2'b01, 2'b01, {8'h00, 8'hFF}, {16'h0000, 16'h00FF});
        idle(2);
        step(2'b10, 2'b00, {8'hFF, 8'h00}, '0);
        idle(3);
        check("t3_rdata", 32'(rsp_rdata), 32'h00FF);
        check("t3_addr_hold", 32'(memoryAddress), 32'hFF);

        // Req1 waits while req0's read is in flight.
        step(2'b01, 2'b00, {8'h00, 8'h05}, '0);
        c0 = last_grant_cyc;
        for (int i = 0; i < 10 && last_grant_cyc == c0; i++)
            step(2'b10, 2'b00, {8'h02, 8'h00}, '0);
        idle(3);
        check("t4_accept_gap", 32'(last_grant_cyc - c0), 32'd3);

        // Back-to-back reads by req0, then a write ack from req1.
        rsp_cycles.delete();
        rsp_datas.delete();
        step(2'b01, 2'b00, {8'h00, 8'h01}, '0);
        c0 = last_grant_cyc;
        for (int i = 0; i < 10 && last_grant_cyc == c0; i++)
            step(2'b01, 2'b00, {8'h00, 8'h02}, '0);
        idle(3);
        step(2'b10, 2'b10, {8'h30, 8'h00}, {16'h7777, 16'h0000});
        idle(3);
        check("t6_npulses", 32'(rsp_cycles.size()), 32'd3);
        if (rsp_cycles.size() >= 3) begin
            check("t6_spacing", 32'(rsp_cycles[1] - rsp_cycles[0]), 32'd3);
            check("t6_data0", 32'(rsp_datas[0]), 32'hAAAA);
            check("t6_data1", 32'(rsp_datas[1]), 32'h5555);
            check("t6_wack_data", 32'(rsp_datas[2]), 32'h5555);
        end
        check("t6_rdata_hold", 32'(rsp_rdata), 32'h5555);

        // Reset lands in ISSUE of a write: the write must be dropped.
        step(2'b01, 2'b01, {8'h00, 8'h10}, {16'h0000, 16'hBEEF});
        req_valid = '0;
        check("t5_mw_pre", 32'(memoryWrite), 32'd1);
        rsp_cycles.delete();
        do_reset();
        idle(2);
        check("t5_no_rsp", 32'(rsp_cycles.size()), 32'd0);
        step(2'b01, 2'b00, {8'h00, 8'h10}, '0);
        idle(3);
        check("t5_old_data", 32'(rsp_rdata), 32'h0F0F);

        // Randomized traffic against the model.
        for (int r = 0; r < 500; r++) begin
            logic [NREQ-1:0]       v;
            logic [NREQ-1:0]       w;
            logic [NREQ*WIDTH-1:0] a;
            logic [NREQ*DW-1:0]    d;
            for (int i = 0; i < NREQ; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                w[i] = 1'($urandom_range(0, 1));
                a[i*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 1) ?
                    WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom_range(248, 255));
                d[i*DW +: DW] = DW'($urandom);
            end
            step(v, w, a, d);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
